turret_servo_pwm: RTL and testbench
===================================

# turret_servo_pwm

APB3 slave that generates the turret servo PWM waveform in the fabric. Clocked by the fabric clock that the MSS clock-conditioning stage produces (RCOSC bypass, 100 MHz), it is the first fabric consumer of that clock. Software writes a period and a target pulse width. The block applies them glitch-free at period boundaries, optionally slew-limited, and raises a per-period interrupt.

## Interface
- PRESCALE, 100: PCLK cycles per PWM tick (1 µs at 100 MHz); valid range 2..65535.
- CNT_W, 16: width of the period/pulse counters, in ticks.
- PULSE_MIN, 500: lower clamp for the target pulse, in ticks.
- PULSE_MAX, 2500: upper clamp for the target pulse, in ticks.

Ports:
- PCLK  in  1  fabric clock; all logic is on the rising edge.
- PRESETN  in  1  asynchronous, active-low reset.
- PSEL, PENABLE, PWRITE  in  1 each  APB3 control.
- PADDR  in  5  byte address; PADDR[4:2] selects the register.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data; zero for unmapped offsets.
- PREADY  out  1  tied to 1.
- PSLVERR  out  1  tied to 0.
- PWM_OUT  out  1  servo drive, registered.
- IRQ  out  1  level interrupt, CTRL.IRQ_EN & STATUS.DONE.

## Operation
Register map:
- 0x00 CTRL (RW, reset 0): bit0 EN, bit1 IRQ_EN.
- 0x04 PERIOD (RW, reset 20000): writes below PULSE_MAX+1 are clamped to PULSE_MAX+1.
- 0x08 TARGET (RW, reset 1500): writes are clamped to [PULSE_MIN, PULSE_MAX].
- 0x0C STATUS: bit0 DONE (sticky, W1C); bit1 RAMPING (RO, CURRENT≠TARGET).
- 0x10 CURRENT (RO, reset 1500): the pulse width in use for the running period.
- 0x14 STEP (RW, reset 10): slew step; see Configuration.

Tick and counting:
- The prescaler counts 0..PRESCALE-1 and asserts a one-cycle tick at PRESCALE-1.
- The tick counter CNT advances on each tick and wraps to 0 after reaching ACT_PERIOD-1.
- The wrap is the period boundary.
- At the boundary, ACT_PERIOD←PERIOD, CURRENT←next pulse, and DONE←1.

Output and enable:
- PWM_OUT is next-cycle EN & (CNT < CURRENT).
- On an EN 0→1 write: prescaler and CNT clear to 0, and ACT_PERIOD/CURRENT load immediately. CURRENT loads TARGET directly; no slew applies.
- While EN=0: counters are held at 0, PWM_OUT=0, and DONE is not set.
- Write-1-to-clear of DONE in the same cycle as a boundary set: the set wins.
- PERIOD or TARGET writes mid-period never change the running period. They apply at the next boundary only.

## Timing
- APB has zero wait states. Writes take effect at the PCLK edge that ends the access phase (PSEL&PENABLE&PWRITE).
- Reads are combinational from registers during the access phase.
- Enable latency: if EN is written at edge E, PWM_OUT rises at E+1. It stays high for CURRENT·PRESCALE cycles, and the period is ACT_PERIOD·PRESCALE cycles.
- DONE and IRQ assert the cycle after the wrap edge.
- Reset values: PWM_OUT=0, IRQ=0, PRDATA=0, counters 0, all registers as listed in the register map.
- Asserting PRESETN mid-period drops PWM_OUT immediately (asynchronous reset).

## Configuration
Macro: TURRET_SERVO_SLEW_EN.
- Defined: at each boundary, CURRENT moves toward TARGET by min(STEP, |TARGET−CURRENT|). STEP=0 means CURRENT←TARGET.
- Undefined: CURRENT←TARGET at each boundary. STEP reads 0 and writes to it are ignored.

## Structure
- Package turret_servo_pkg holds the register offset constants, the reset defaults (20000, 1500, 10), and the CTRL/STATUS bit indices.
- Sub-module turret_servo_tick implements the PRESCALE prescaler: inputs clear and run, output tick.

## Test plan
- Reset, then read all registers -> CTRL=0, PERIOD=20000, TARGET=1500, CURRENT=1500, PWM_OUT=0, IRQ=0.
- PRESCALE=4; write PERIOD=3000, TARGET=1000, EN=1 -> PWM_OUT high 4000 cycles of every 12000; DONE set every 12000 cycles.
- Write TARGET=100 and then TARGET=9000 -> reads back 500 and 2500. Write PERIOD=10 -> reads back 2501.
- Change TARGET 1000→2000 mid-period -> the current period keeps 1000 ticks high; the next period uses the new value (macro off).
- Macro on, STEP=100, TARGET 1500→2000 -> CURRENT reads 1600, 1700, 1800, 1900, 2000 on successive boundaries; RAMPING clears after 2000.
- IRQ_EN=1: W1C of DONE issued on the same cycle as a boundary -> DONE stays 1. Clear it mid-period -> IRQ deasserts the next cycle.

Source files
------------

// File: rtl/turret_servo_pkg.sv
// turret_servo_pkg: register offsets, reset defaults, bit indices and clamp helper for turret_servo_pwm
package turret_servo_pkg;

    typedef enum logic [2:0] {
        REG_CTRL    = 3'd0,
        REG_PERIOD  = 3'd1,
        REG_TARGET  = 3'd2,
        REG_STATUS  = 3'd3,
        REG_CURRENT = 3'd4,
        REG_STEP    = 3'd5
    } reg_e;

    localparam logic [4:0] OFF_CTRL    = 5'h00;
    localparam logic [4:0] OFF_PERIOD  = 5'h04;
    localparam logic [4:0] OFF_TARGET  = 5'h08;
    localparam logic [4:0] OFF_STATUS  = 5'h0C;
    localparam logic [4:0] OFF_CURRENT = 5'h10;
    localparam logic [4:0] OFF_STEP    = 5'h14;

    localparam int unsigned PERIOD_RST = 20000;
    localparam int unsigned TARGET_RST = 1500;
    localparam int unsigned STEP_RST   = 10;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_IRQ_EN    = 1;
    localparam int STATUS_DONE    = 0;
    localparam int STATUS_RAMPING = 1;

    // Saturate a bus write into [lo, hi].
    function automatic logic [31:0] clamp(input logic [31:0] v, input logic [31:0] lo, input logic [31:0] hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

endpackage

// File: rtl/turret_servo_pwm_if.sv
// turret_servo_pwm_if: APB3 slave bus bundle with master/slave views
interface turret_servo_pwm_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [4:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/turret_servo_tick.sv
// turret_servo_tick: PCLK prescaler producing a one-cycle tick every PRESCALE cycles
module turret_servo_tick #(
    parameter int PRESCALE = 100
) (
    input  logic PCLK,
    input  logic PRESETN,
    input  logic i_clear,
    input  logic i_run,
    output logic o_tick
);
    localparam int W = $clog2(PRESCALE);

    logic [W-1:0] r_pre;

    assign o_tick = i_run & (r_pre == W'(PRESCALE - 1));

    // Count 0..PRESCALE-1 while running; idle or restart holds at zero.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) r_pre <= '0;
        else          r_pre <= (i_clear | !i_run | o_tick) ? '0 : r_pre + 1'b1;
    end
endmodule

// File: rtl/turret_servo_pwm.sv
// turret_servo_pwm: APB3 servo PWM generator with boundary-synchronous updates; slew limiting under TURRET_SERVO_SLEW_EN
module turret_servo_pwm
    import turret_servo_pkg::*;
#(
    parameter int PRESCALE  = 100,
    parameter int CNT_W     = 16,
    parameter int PULSE_MIN = 500,
    parameter int PULSE_MAX = 2500
) (
    input  logic                PCLK,
    input  logic                PRESETN,
    turret_servo_pwm_if.slave   apb,
    output logic                PWM_OUT,
    output logic                IRQ
);
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 1);

    logic             r_en, r_irq_en, r_done, r_pwm;
    logic [CNT_W-1:0] r_period, r_target, r_current, r_act_per, r_cnt;
    logic [CNT_W-1:0] w_next, w_per_wd, w_tgt_wd;
    logic [31:0]      w_rdata, w_step_rd;
    logic             w_wr, w_rd, w_tick, w_wrap, w_en_rise, w_done_clr, w_unused;
    reg_e             w_sel;

    assign w_sel      = reg_e'(apb.PADDR[4:2]);
    assign w_unused   = ^apb.PADDR[1:0];
    assign w_wr       = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign w_rd       = apb.PSEL & apb.PENABLE & !apb.PWRITE;
    assign w_en_rise  = w_wr & (w_sel == REG_CTRL) & apb.PWDATA[CTRL_EN] & !r_en;
    assign w_done_clr = w_wr & (w_sel == REG_STATUS) & apb.PWDATA[STATUS_DONE];
    assign w_wrap     = w_tick & (r_cnt == r_act_per - CNT_W'(1));
    assign w_per_wd   = CNT_W'(clamp(apb.PWDATA, 32'(PULSE_MAX + 1), CNT_MAX));
    assign w_tgt_wd   = CNT_W'(clamp(apb.PWDATA, 32'(PULSE_MIN), 32'(PULSE_MAX)));

    turret_servo_tick #(.PRESCALE(PRESCALE)) u_tick (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .i_clear (w_en_rise),
        .i_run   (r_en),
        .o_tick  (w_tick)
    );

`ifdef TURRET_SERVO_SLEW_EN
    logic [CNT_W-1:0] r_step, w_dist;
    logic             w_up;

    // Step CURRENT toward TARGET, landing exactly on it when within one step.
    always_comb begin
        w_up   = r_target > r_current;
        w_dist = w_up ? r_target - r_current : r_current - r_target;
        w_next = (r_step == '0 || w_dist <= r_step) ? r_target : w_up ? r_current + r_step : r_current - r_step;
    end

    // Slew step register.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN)                         r_step <= CNT_W'(STEP_RST);
        else if (w_wr && w_sel == REG_STEP)   r_step <= apb.PWDATA[CNT_W-1:0];
    end

    assign w_step_rd = 32'(r_step);
`else
    assign w_next    = r_target;
    assign w_step_rd = '0;
`endif

    // Software-visible control registers, with clamping applied on write.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_en     <= 1'b0;
            r_irq_en <= 1'b0;
            r_period <= CNT_W'(PERIOD_RST);
            r_target <= CNT_W'(TARGET_RST);
        end else begin
            if (w_wr && w_sel == REG_CTRL) begin
                r_en     <= apb.PWDATA[CTRL_EN];
                r_irq_en <= apb.PWDATA[CTRL_IRQ_EN];
            end
            if (w_wr && w_sel == REG_PERIOD) r_period <= w_per_wd;
            if (w_wr && w_sel == REG_TARGET) r_target <= w_tgt_wd;
        end
    end

    // PWM engine: tick counter, boundary shadow loads, sticky DONE and registered output.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_cnt     <= '0;
            r_act_per <= CNT_W'(PERIOD_RST);
            r_current <= CNT_W'(TARGET_RST);
            r_done    <= 1'b0;
            r_pwm     <= 1'b0;
        end else begin
            if (!r_en)       r_cnt <= '0;
            else if (w_tick) r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
            if (w_en_rise) begin
                r_act_per <= r_period;
                r_current <= r_target;
            end else if (w_wrap) begin
                r_act_per <= r_period;
                r_current <= w_next;
            end
            r_done <= w_wrap | (r_done & !w_done_clr);
            r_pwm  <= r_en & (r_cnt < r_current);
        end
    end

    // Register read mux; unmapped offsets read as zero.
    always_comb begin
        w_rdata = '0;
        case (w_sel)
            REG_CTRL:    w_rdata = {30'b0, r_irq_en, r_en};
            REG_PERIOD:  w_rdata = 32'(r_period);
            REG_TARGET:  w_rdata = 32'(r_target);
            REG_STATUS:  w_rdata = {30'b0, r_current != r_target, r_done};
            REG_CURRENT: w_rdata = 32'(r_current);
            REG_STEP:    w_rdata = w_step_rd;
            default:     w_rdata = '0;
        endcase
    end

    assign apb.PRDATA  = w_rd ? w_rdata : '0;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = 1'b0;
    assign PWM_OUT     = r_pwm;
    assign IRQ         = r_irq_en & r_done;
endmodule

// File: tb/tb_turret_servo_pwm.sv
// tb_turret_servo_pwm: directed self-checking bench for turret_servo_pwm (PRESCALE=4); slew path under TURRET_SERVO_SLEW_EN
module tb_turret_servo_pwm;
    import turret_servo_pkg::*;

    localparam int PS = 4;

    logic PCLK, PRESETN, PWM_OUT, IRQ;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   e0, w1, w2, w3, e2;
    logic [31:0] rd;

    turret_servo_pwm_if bus ();

    turret_servo_pwm #(.PRESCALE(PS)) dut (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .apb     (bus),
        .PWM_OUT (PWM_OUT),
        .IRQ     (IRQ)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic goto_cyc(input int n);
        int d;
        d = n - cyc;
        if (d < 0) begin
            checks++;
            failures++;
            $error("FAIL goto observed=%0d expected<=%0d", cyc, n);
        end else if (d > 0) begin
            repeat (d) @(posedge PCLK);
            #1;
        end
    endtask

    task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = a; bus.PWDATA = d;
        @(posedge PCLK); #1 bus.PENABLE = 1'b1;
        @(posedge PCLK); #1 bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [4:0] a, output logic [31:0] d);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = a;
        @(posedge PCLK); #1 bus.PENABLE = 1'b1;
        #1 d = bus.PRDATA;
        @(posedge PCLK); #1 bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] v;
        apb_read(a, v);
        chk(tag, v, exp);
    endtask

    initial begin
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
        PRESETN = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_pwm", PWM_OUT, 0);
        chk("rst_irq", IRQ, 0);
        chk("rst_prdata", bus.PRDATA, 0);
        chk("pready", bus.PREADY, 1);
        chk("pslverr", bus.PSLVERR, 0);
        PRESETN = 1'b1;
        @(posedge PCLK); #1;

        rd_chk("rst_ctrl", OFF_CTRL, 0);
        rd_chk("rst_period", OFF_PERIOD, 20000);
        rd_chk("rst_target", OFF_TARGET, 1500);
        rd_chk("rst_status", OFF_STATUS, 0);
        rd_chk("rst_current", OFF_CURRENT, 1500);
        rd_chk("unmapped", 5'h18, 0);
`ifdef TURRET_SERVO_SLEW_EN
        rd_chk("rst_step", OFF_STEP, 10);
        apb_write(OFF_STEP, 100);
        rd_chk("step_wr", OFF_STEP, 100);
`else
        rd_chk("rst_step", OFF_STEP, 0);
        apb_write(OFF_STEP, 100);
        rd_chk("step_wr", OFF_STEP, 0);
`endif

        apb_write(OFF_TARGET, 100);
        rd_chk("tgt_lo_clamp", OFF_TARGET, 500);
        apb_write(OFF_TARGET, 9000);
        rd_chk("tgt_hi_clamp", OFF_TARGET, 2500);
        rd_chk("status_ramp", OFF_STATUS, 2);
        apb_write(OFF_PERIOD, 10);
        rd_chk("per_clamp", OFF_PERIOD, 2501);
        rd_chk("idle_cur", OFF_CURRENT, 1500);

        apb_write(OFF_PERIOD, 3000);
        apb_write(OFF_TARGET, 1000);
        apb_write(OFF_CTRL, 1);
        e0 = cyc;
        chk("en_edge_pwm", PWM_OUT, 0);
        goto_cyc(e0 + 1);
        chk("en_rise_pwm", PWM_OUT, 1);
        rd_chk("p1_status", OFF_STATUS, 0);
        rd_chk("p1_current", OFF_CURRENT, 1000);
        goto_cyc(e0 + 4000);
        chk("p1_last_hi", PWM_OUT, 1);
        goto_cyc(e0 + 4001);
        chk("p1_fall", PWM_OUT, 0);
        w1 = e0 + 3000 * PS;
        goto_cyc(w1);
        chk("p1_end_lo", PWM_OUT, 0);
        goto_cyc(w1 + 1);
        chk("p2_rise", PWM_OUT, 1);
        chk("irq_gated", IRQ, 0);
        rd_chk("p1_done", OFF_STATUS, 1);

`ifdef TURRET_SERVO_SLEW_EN
        apb_write(OFF_CTRL, 0);
        apb_write(OFF_TARGET, 1500);
        chk("dis_pwm", PWM_OUT, 0);
        apb_write(OFF_PERIOD, 2501);
        apb_write(OFF_CTRL, 1);
        e2 = cyc;
        rd_chk("en_load_cur", OFF_CURRENT, 1500);
        apb_write(OFF_TARGET, 2000);
        rd_chk("slew_status", OFF_STATUS, 3);
        for (int k = 1; k <= 4; k++) begin
            goto_cyc(e2 + k * 2501 * PS + 1);
            rd_chk("slew_cur", OFF_CURRENT, 32'(1500 + 100 * k));
        end
        w3 = e2 + 5 * 2501 * PS;
        apb_write(OFF_CTRL, 3);
        chk("irq_on", IRQ, 1);
        apb_write(OFF_STATUS, 1);
        chk("irq_clr", IRQ, 0);
        rd_chk("clr_status", OFF_STATUS, 2);
        goto_cyc(w3 - 2);
        apb_write(OFF_STATUS, 1);
        chk("w1c_vs_set_irq", IRQ, 1);
        rd_chk("slew_done_status", OFF_STATUS, 1);
        rd_chk("slew_final_cur", OFF_CURRENT, 2000);
`else
        apb_write(OFF_TARGET, 2000);
        rd_chk("mid_cur", OFF_CURRENT, 1000);
        rd_chk("mid_status", OFF_STATUS, 3);
        goto_cyc(w1 + 4000);
        chk("p2_last_hi", PWM_OUT, 1);
        goto_cyc(w1 + 4001);
        chk("p2_fall", PWM_OUT, 0);
        w2 = w1 + 3000 * PS;
        goto_cyc(w2 + 1);
        chk("p3_rise", PWM_OUT, 1);
        rd_chk("p3_current", OFF_CURRENT, 2000);
        goto_cyc(w2 + 8000);
        chk("p3_last_hi", PWM_OUT, 1);
        goto_cyc(w2 + 8001);
        chk("p3_fall", PWM_OUT, 0);
        apb_write(OFF_CTRL, 3);
        chk("irq_on", IRQ, 1);
        apb_write(OFF_STATUS, 1);
        chk("irq_clr", IRQ, 0);
        rd_chk("clr_status", OFF_STATUS, 0);
        w3 = w2 + 3000 * PS;
        goto_cyc(w3 - 2);
        apb_write(OFF_STATUS, 1);
        chk("w1c_vs_set_irq", IRQ, 1);
        rd_chk("w1c_vs_set_status", OFF_STATUS, 1);
`endif

        chk("pre_arst_pwm", PWM_OUT, 1);
        #2 PRESETN = 1'b0;
        #1;
        chk("arst_pwm", PWM_OUT, 0);
        chk("arst_irq", IRQ, 0);
        @(posedge PCLK); #1 PRESETN = 1'b1;
        rd_chk("arst_ctrl", OFF_CTRL, 0);
        rd_chk("arst_current", OFF_CURRENT, 1500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
